mem8x8_requester: RTL and testbench

- Bus-side initiator for the 8x8 memory access FSM. It drives that FSM's op/sel inputs and consumes its valid/rw outputs.
- Accepts one host command at a time (read or write of one 8-bit word at a 3-bit address) and sequences the op/sel handshake.
- Drives the shared tri-state data bus only during writes, captures read data, and returns a one-cycle response.
- Sits between the host/testbench logic and the mem8x8 + tri-state buffer datapath.

---
 rtl/mem8x8_pkg.sv | 18 +
 rtl/mem8x8_tristate_drv.sv | 13 +
 rtl/mem8x8_requester.sv | 133 +++++++++++++
 tb/tb_mem8x8_requester.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem8x8_pkg.sv
// Shared definitions for the mem8x8 requester and memory side:
// FSM state encoding, op encoding and default bus widths.
package mem8x8_pkg;

   localparam int AW_DEF = 3;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem8x8_tristate_drv.sv
// Tri-state driver for the shared mem8x8 data bus: drives din when en, else Z.
// Used by the requester and reusable by the memory side.
module mem8x8_tristate_drv #(
   parameter int DW = 8
) (
   input  logic          en,
   input  logic [DW-1:0] din,
   inout  wire  [DW-1:0] bus
);

   assign bus = en ? din : {DW{1'bz}};

endmodule

// File: rtl/mem8x8_requester.sv
// Bus-side initiator for the mem8x8 access FSM: one host command at a time,
// op/sel handshake, write-only bus drive. Optional: MEM8X8_REQ_TIMEOUT_EN.
import mem8x8_pkg::*;

module mem8x8_requester #(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          op,
   output logic          sel,
   input  logic          valid,
   input  logic          rw,
   output logic [AW-1:0] addr,
   inout  wire  [DW-1:0] data
);

   state_t        r_state;
   logic          r_sel;
   logic          r_op;
   logic          r_drv;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_rsp_valid;
   logic          w_accept;
   logic          w_match;

   // Reset forces IDLE asynchronously, so gate ready with rst to hold it low.
   assign cmd_ready = (r_state == IDLE) && !rst;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_match   = valid && (rw == r_op);

   assign sel       = r_sel;
   assign op        = r_op;
   assign addr      = r_addr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;

`ifdef MEM8X8_REQ_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
   logic [3:0] r_cnt;
   logic       r_rsp_err;
   assign rsp_err = r_rsp_err;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^TIMEOUT;
   assign rsp_err      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sel       <= 1'b0;
         r_op        <= OP_READ;
         r_drv       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
`ifdef MEM8X8_REQ_TIMEOUT_EN
         r_cnt       <= '0;
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
`ifdef MEM8X8_REQ_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= REQ;
                  r_sel   <= 1'b1;
                  r_op    <= cmd_we;
                  r_drv   <= cmd_we;
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
`ifdef MEM8X8_REQ_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            REQ: begin
               // A grant in the wrong direction is not ours; keep waiting.
               if (w_match) begin
                  r_state <= XFER;
`ifdef MEM8X8_REQ_TIMEOUT_EN
               end else if (r_cnt == TMO_LAST) begin
                  r_state     <= GAP;
                  r_sel       <= 1'b0;
                  r_op        <= OP_READ;
                  r_drv       <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
`endif
               end
            end
            XFER: begin
               if (r_op == OP_READ) r_rdata <= data;
               r_state     <= GAP;
               r_sel       <= 1'b0;
               r_op        <= OP_READ;
               r_drv       <= 1'b0;
               r_rsp_valid <= 1'b1;
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem8x8_tristate_drv #(.DW(DW)) u_data_drv (
      .en  (r_drv),
      .din (r_wdata),
      .bus (data)
   );

endmodule

// File: tb/tb_mem8x8_requester.sv
// Self-checking bench for mem8x8_requester: behavioural memory FSM model on
// the op/sel/valid/rw/data side, scoreboard of expected responses.
module tb_mem8x8_requester;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_we = 1'b0;
   logic [2:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   wire        cmd_ready, rsp_valid, rsp_err, op, sel;
   wire  [7:0] rsp_rdata;
   wire  [2:0] addr;
   logic       valid = 1'b0;
   logic       rw = 1'b0;
   wire  [7:0] data;
   logic       m_drv = 1'b0;
   logic [7:0] m_q = '0;

   assign data = m_drv ? m_q : 8'bz;

   always #5 clk = ~clk;

   mem8x8_requester dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .op(op), .sel(sel), .valid(valid), .rw(rw), .addr(addr), .data(data)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   typedef struct { logic [7:0] rdata; logic err; } exp_t;
   exp_t sb[$];

   logic [7:0] mem [8];
   logic [7:0] ref_mem [8];
   logic [7:0] last_rd = '0;

   // Memory-side model knobs
   int mdl_delay = 1;
   int mdl_bad = 0;
   bit mdl_never = 1'b0;
   bit mdl_drop = 1'b0;
   int m_cnt = 0;
   int m_bad_left = 0;

   // Command currently owned by the requester
   logic       c_we = 1'b0;
   logic [2:0] c_addr = '0;
   logic [7:0] c_wd = '0;

   int   low_run = 0;
   int   last_low_run = 0;
   logic prev_sel = 1'b0;
   logic prev_rsp = 1'b0;

   always @(negedge clk) begin
      if (rst || !sel) begin
         m_cnt = 0; valid = 1'b0; rw = 1'b0; m_bad_left = mdl_bad;
      end else begin
         if (op && valid && rw) mem[addr] = data;
         m_cnt++;
         if (mdl_drop && valid && (rw == op)) valid = 1'b0;
         else if (!mdl_never && m_cnt >= mdl_delay) begin
            valid = 1'b1;
            if (m_bad_left > 0) begin rw = ~op; m_bad_left--; end
            else rw = op;
         end
      end
      m_drv = !rst && sel && !op && valid && !rw;
      m_q   = mem[addr];
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (sel) begin
            chk("op", op, c_we);
            chk("addr", addr, c_addr);
            if (op) chk("wr_data", data, c_wd);
         end
         if (rsp_valid) begin
            chk("gap_sel", sel, 0);
            chk("gap_op", op, 0);
            chk("gap_ready", cmd_ready, 0);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", rsp_err, e.err);
            end
         end
         if (prev_rsp) chk("ready_after_rsp", cmd_ready, 1);
         if (sel) begin
            if (!prev_sel) last_low_run = low_run;
            low_run = 0;
         end else low_run++;
         prev_sel = sel;
         prev_rsp = rsp_valid;
      end
   end

   task automatic push_exp(input logic we, input logic [2:0] a, input logic [7:0] wd, input logic tmo);
      if (tmo) sb.push_back('{last_rd, 1'b1});
      else if (we) begin
         ref_mem[a] = wd;
         sb.push_back('{last_rd, 1'b0});
      end else begin
         last_rd = ref_mem[a];
         sb.push_back('{last_rd, 1'b0});
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      @(negedge clk);
      n = 1;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("ready_wait", cmd_ready, 1);
   endtask

   task automatic send(input logic we, input logic [2:0] a, input logic [7:0] wd, input logic tmo);
      int n;
      wait_ready(n);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
      push_exp(we, a, wd, tmo);
      @(posedge clk); #1;
      c_we = we; c_addr = a; c_wd = wd;
      cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = 3'($urandom); cmd_wdata = 8'($urandom);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 60);
      chk("rsp_seen", rsp_valid, 1);
   endtask

   initial begin
      int lat;
      int n;
      logic [7:0] saved;
      for (int i = 0; i < 8; i++) mem[i] = 8'(i * 37 + 11);
      mem[3] = 8'h5A;
      for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];

      #12;
      chk("rst_ready", cmd_ready, 0);
      chk("rst_sel", sel, 0);
      chk("rst_op", op, 0);
      chk("rst_addr", addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("ready_post_rst", cmd_ready, 1);

      // Read addr 3, grant on 2nd REQ cycle
      mdl_delay = 2;
      send(1'b0, 3'd3, 8'h00, 1'b0); wait_rsp(lat); chk("lat_read", lat, 4);

      // Write 0xC3 to addr 6 with minimum latency, then read it back
      mdl_delay = 1;
      send(1'b1, 3'd6, 8'hC3, 1'b0); wait_rsp(lat); chk("lat_write", lat, 3);
      chk("mem6", mem[6], 8'hC3);
      send(1'b0, 3'd6, 8'h00, 1'b0); wait_rsp(lat); chk("lat_min", lat, 3);

      // Two wrong-direction grants before the right one
      mdl_bad = 2;
      send(1'b1, 3'd2, 8'h3C, 1'b0); wait_rsp(lat); chk("lat_mismatch", lat, 5);
      mdl_bad = 0;
      send(1'b0, 3'd2, 8'h00, 1'b0); wait_rsp(lat);

      // valid drops during XFER
      mdl_drop = 1'b1;
      send(1'b1, 3'd5, 8'h99, 1'b0); wait_rsp(lat); chk("lat_drop", lat, 3);
      mdl_drop = 1'b0;
      chk("mem5", mem[5], 8'h99);

      // Back-to-back: cmd_valid held, read then write
      wait_ready(n);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd2; cmd_wdata = 8'h00;
      push_exp(1'b0, 3'd2, 8'h00, 1'b0);
      @(posedge clk); #1;
      c_we = 1'b0; c_addr = 3'd2; c_wd = 8'h00;
      cmd_we = 1'b1; cmd_addr = 3'd7; cmd_wdata = 8'h77;
      push_exp(1'b1, 3'd7, 8'h77, 1'b0);
      wait_ready(n);
      chk("b2b_ready_wait", n, 4);
      @(posedge clk); #1;
      c_we = 1'b1; c_addr = 3'd7; c_wd = 8'h77;
      cmd_valid = 1'b0;
      wait_rsp(lat);
      chk("b2b_sel_low", last_low_run, 2);
      chk("mem7", mem[7], 8'h77);

      // No grant for a long time
      mdl_never = 1'b1;
`ifdef MEM8X8_REQ_TIMEOUT_EN
      send(1'b0, 3'd1, 8'h00, 1'b1); wait_rsp(lat); chk("lat_timeout", lat, 16);
      mdl_never = 1'b0;
`else
      send(1'b0, 3'd1, 8'h00, 1'b0);
      repeat (30) @(negedge clk);
      chk("stall_sel", sel, 1);
      chk("stall_rsp", rsp_valid, 0);
      mdl_never = 1'b0;
      wait_rsp(lat);
`endif

      // Reset in the middle of a write request
      mdl_never = 1'b1;
      saved = ref_mem[4];
      send(1'b1, 3'd4, 8'hE1, 1'b0);
      @(negedge clk); #2;
      rst = 1'b1; #1;
      chk("midrst_sel", sel, 0);
      chk("midrst_op", op, 0);
      chk("midrst_ready", cmd_ready, 0);
      chk("midrst_rsp", rsp_valid, 0);
      sb.delete();
      ref_mem[4] = saved;
      @(negedge clk); rst = 1'b0; mdl_never = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", cmd_ready, 1);
      send(1'b0, 3'd4, 8'h00, 1'b0); wait_rsp(lat);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
      $fatal(1);
   end

endmodule
